instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
// - Instruction fetch stage that drives the ROM's byte address and accepts the 32-bit opcode it returns one cycle later.
// - Owns the program counter and absorbs the ROM's 1-cycle registered read latency.
// - Hands instructions to decode over a valid/ready handshake, with a 1-entry skid buffer.
// - Supports redirect (jump/branch), halt and start.
// PARAMETERS
// - ADDR_W    8      ROM byte-address width; PC arithmetic is modulo 2**ADDR_W.
// - DATA_W    32     Opcode width returned by ROM.
// - PC_STEP   4      Bytes per instruction; PC increment.
// - RESET_PC  8'h00  PC value loaded on reset.
// PORTS
// - clk           in   1       Clock, rising edge.
// - rst           in   1       Asynchronous, active-high reset.
// - start         in   1       Pulse: IDLE/HALTED -> RUN.
// - halt          in   1       Pulse: RUN -> HALTED; stops new fetches.
// - jump_valid    in   1       Redirect request; highest priority.
// - jump_addr     in   ADDR_W  Redirect target (any byte alignment allowed).
// - rom_addr      out  ADDR_W  Address to ROM; always equals pc_q.
// - rom_opcode    in   DATA_W  ROM data; corresponds to rom_addr of the previous cycle.
// - instr_valid   out  1       Output instruction valid.
// - instr_ready   in   1       Decode accepts when valid&&ready.
// - instr         out  DATA_W  Instruction word.
// - instr_pc      out  ADDR_W  Address the instruction was fetched from.
// - halted        out  1       High in HALTED state.
// - instr_count   out  16      Delivered-instruction count; wraps at 16'hFFFF.
// BEHAVIOUR
// - Reset (async): state=IDLE, pc_q=RESET_PC, inflight=0, skid empty, instr_valid=0, instr=0, instr_pc=0, halted=0, instr_count=0.
// - FSM
//   - IDLE --start--> RUN; RUN --halt--> HALTED; HALTED --start--> RUN.
//   - jump_valid does not change state.
//   - halt and start in the same cycle: halt wins.
// - Issue (fetch) condition: state==RUN && !jump_valid && !skid_valid && !(inflight && instr_valid && !instr_ready).
//   - On issue: inflight<=1, inflight_pc<=pc_q, pc_q<=pc_q+PC_STEP (wraps 8'hFC -> 8'h00).
//   - Otherwise: inflight<=0.
// - Response (inflight==1): rom_opcode with inflight_pc is written to the output register if it is empty or being consumed this cycle; otherwise to the skid buffer.
// - When the output is consumed and the skid is full, skid contents move to the output and the response goes to the skid (order preserved).
// - Latency: an issue at cycle t gives instr_valid at t+2 when the output is free. Throughput is 1 instr/cycle with instr_ready held high.
// - instr/instr_pc are held stable while instr_valid && !instr_ready.
// - jump_valid:
//   - pc_q <= jump_addr.
//   - Clears inflight, skid and instr_valid the next cycle; the word in flight is discarded.
//   - No issue this cycle; first fetch from jump_addr is at the next cycle if RUN.
//   - If the output is accepted in the same cycle as jump_valid, that word still counts as delivered.
// - halt: no further issues. A word already in flight, the skid and the output still drain normally.
// - instr_count increments on every instr_valid && instr_ready.
// - Reset mid-operation: immediate clear; ROM contents are not touched.
// STRUCTURE
// - Shared package fetch_pkg:
//   - state enum {IDLE, RUN, HALTED}.
//   - ADDR_W/DATA_W/PC_STEP defaults.
//   - Packed struct fetch_word_t {instr, pc}.
// - Sub-module fetch_skid_buf: 1-entry buffer of fetch_word_t with push/pop/flush and valid.
// - Remaining logic stays in the top: FSM, PC, in-flight tracking, output register, counter.
// TESTING
// - Reset, start, instr_ready=1 -> rom_addr 00,04,08...; first instr_valid 2 cycles after start; instr_pc matches; instr_count increments each cycle.
// - Hold instr_ready=0 for 5 cycles mid-stream -> instr stable, at most 2 words buffered, no issue; on release, words come out in order with no gaps or duplicates.
// - PC wrap: jump to 8'hF8 -> instr_pc sequence F8, FC, 00, 04.
// - Jump to 8'h40 with one word in flight and one in the skid -> both dropped; next delivered instr_pc=40, then 44.
// - halt with one word in flight -> that word is delivered, halted=1, rom_addr frozen; start resumes from the frozen PC.
// - Assert rst mid-stream with instr_valid=1 -> outputs clear asynchronously; after release, state=IDLE and pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage.
// Contents:
//   - ADDR_W / DATA_W / PC_STEP / RESET_PC default values
//   - state_t      : fetch FSM states (IDLE, RUN, HALTED)
//   - fetch_word_t : an instruction word together with the address it came from
package fetch_pkg;

    localparam int          ADDR_W   = 8;
    localparam int          DATA_W   = 32;
    localparam int          PC_STEP  = 4;
    localparam logic [7:0]  RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word while the output register is
// stalled.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push      : load din (takes precedence over pop, so push+pop replaces the entry)
//   pop       : entry has been taken by the consumer
//   flush     : discard the entry (highest priority)
//   din       : word to store
//   valid     : entry present
//   dout      : stored word
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fetch_word_t din,
    output logic        valid,
    output fetch_word_t dout
);

    logic        valid_r;
    fetch_word_t word_r;

    // Entry storage: flush beats push, push beats pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            word_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (push) begin
            valid_r <= 1'b1;
            word_r  <= din;
        end else if (pop) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign dout  = word_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Drives the ROM byte address from the program
// counter, captures the opcode the ROM returns one cycle later and presents it
// to decode over a valid/ready handshake. A one-entry skid buffer catches the
// word that is already in flight when decode stalls.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start, halt           : FSM control pulses (halt wins when both are high)
//   jump_valid, jump_addr : redirect the PC, dropping everything in the pipe
//   rom_addr, rom_opcode  : ROM interface (1-cycle registered read)
//   instr_valid, instr_ready, instr, instr_pc : decode handshake
//   halted                : high while in HALTED
//   instr_count           : number of delivered instructions (wraps)
module instr_fetch #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                DATA_W   = fetch_pkg::DATA_W,
    parameter int                PC_STEP  = fetch_pkg::PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_opcode,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
    output logic [15:0]       instr_count
);

    import fetch_pkg::*;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic              inflight_r;
    logic              out_valid_r;
    fetch_word_t       out_word_r;
    logic [15:0]       count_r;
    logic              halted_r;

    logic              consume_s;
    logic              issue_s;
    logic              resp_s;
    fetch_word_t       resp_word_s;
    logic              skid_valid_s;
    fetch_word_t       skid_word_s;
    logic              skid_push_s;
    logic              skid_pop_s;
    logic              out_valid_next_s;
    fetch_word_t       out_word_next_s;

    // FSM next state; halt takes priority over start in every state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !halt) state_s = RUN;
                else                state_s = IDLE;
            end
            RUN: begin
                if (halt) state_s = HALTED;
                else      state_s = RUN;
            end
            HALTED: begin
                if (start && !halt) state_s = RUN;
                else                state_s = HALTED;
            end
            default: state_s = IDLE;
        endcase
    end

    // Issue decision and routing of the returning ROM word between the output
    // register and the skid buffer.
    always_comb begin
        consume_s        = out_valid_r && instr_ready;
        // A new fetch may only start if its word is guaranteed a slot: the skid
        // must be empty, and a stalled output with a word already in flight
        // would use that last slot.
        issue_s          = (state_r == RUN) && !jump_valid && !skid_valid_s &&
                           !(inflight_r && out_valid_r && !instr_ready);
        // A redirect discards the word returning this cycle.
        resp_s           = inflight_r && !jump_valid;
        resp_word_s      = '{instr: rom_opcode, pc: inflight_pc_r};
        skid_push_s      = 1'b0;
        skid_pop_s       = 1'b0;
        out_valid_next_s = out_valid_r;
        out_word_next_s  = out_word_r;
        if (jump_valid) begin
            out_valid_next_s = 1'b0;
        end else if (consume_s || !out_valid_r) begin
            if (skid_valid_s) begin
                // Older skid word goes out first; the new response backfills.
                out_word_next_s  = skid_word_s;
                out_valid_next_s = 1'b1;
                skid_pop_s       = 1'b1;
                skid_push_s      = resp_s;
            end else if (resp_s) begin
                out_word_next_s  = resp_word_s;
                out_valid_next_s = 1'b1;
            end else begin
                out_valid_next_s = 1'b0;
            end
        end else begin
            skid_push_s = resp_s;
        end
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (skid_push_s),
        .pop   (skid_pop_s),
        .flush (jump_valid),
        .din   (resp_word_s),
        .valid (skid_valid_s),
        .dout  (skid_word_s)
    );

    // State, PC, in-flight tracking, output register and delivery counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            halted_r      <= 1'b0;
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            out_valid_r   <= 1'b0;
            out_word_r    <= '0;
            count_r       <= 16'd0;
        end else begin
            state_r     <= state_s;
            halted_r    <= (state_s == HALTED);
            inflight_r  <= issue_s;
            out_valid_r <= out_valid_next_s;
            out_word_r  <= out_word_next_s;
            if (jump_valid) begin
                pc_r <= jump_addr;
            end else if (issue_s) begin
                pc_r <= pc_r + ADDR_W'(PC_STEP);
            end else begin
                pc_r <= pc_r;
            end
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end else begin
                inflight_pc_r <= inflight_pc_r;
            end
            if (consume_s) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign rom_addr    = pc_r;
    assign instr_valid = out_valid_r;
    assign instr       = out_word_r.instr;
    assign instr_pc    = out_word_r.pc;
    assign halted      = halted_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. The bench models a registered ROM whose
// word at byte address A is {24'hC0DE00, A}, so every expected opcode follows
// from the expected fetch address.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic        jump_valid;
    logic [7:0]  jump_addr;
    logic [7:0]  rom_addr;
    logic [31:0] rom_opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        halted;
    logic [15:0] instr_count;

    int tests_run;
    int tests_failed;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .rom_addr    (rom_addr),
        .rom_opcode  (rom_opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: one-cycle registered read, unaffected by reset.
    initial rom_opcode = 32'd0;
    always @(posedge clk) rom_opcode <= {24'hC0DE00, rom_addr};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Watch the handshake at falling edges and expect n consecutive deliveries
    // starting at first_pc, stepping by 4. Returns at the falling edge where
    // the last expected word is presented (it is consumed on the next rise).
    task automatic expect_stream(input string tag, input logic [7:0] first_pc,
                                 input int n, input int budget);
        logic [7:0] exp_pc;
        int got;
        exp_pc = first_pc;
        got    = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (instr_valid && instr_ready) begin
                check_eq({tag, "_pc"}, {24'd0, instr_pc}, {24'd0, exp_pc});
                check_eq({tag, "_instr"}, instr, {24'hC0DE00, exp_pc});
                exp_pc = exp_pc + 8'd4;
                got++;
            end
            if (got < n) @(negedge clk);
        end
        check_eq({tag, "_words"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_pc;
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start        = 1'b0;
        halt         = 1'b0;
        jump_valid   = 1'b0;
        jump_addr    = 8'h00;
        instr_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr",  instr, 32'd0);
        check_eq("rst_pc",     {24'd0, instr_pc}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_count",  {16'd0, instr_count}, 32'd0);
        check_eq("rst_addr",   {24'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_addr", {24'd0, rom_addr}, 32'd0);

        // Start and stream with ready held high
        start       = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("s1_addr",  {24'd0, rom_addr}, 32'h00);
        check_eq("s1_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_eq("s2_addr",  {24'd0, rom_addr}, 32'h04);
        check_eq("s2_valid", {31'd0, instr_valid}, 32'd0);
        exp_pc = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("run_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("run_pc",    {24'd0, instr_pc}, {24'd0, exp_pc});
            check_eq("run_instr", instr, {24'hC0DE00, exp_pc});
            check_eq("run_count", {16'd0, instr_count}, k);
            check_eq("run_addr",  {24'd0, rom_addr}, {24'd0, exp_pc + 8'h08});
            exp_pc = exp_pc + 8'd4;
        end

        // Stall: output 0x14 held, 0x18 parked in the skid, fetch frozen at 0x1C
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("stall_pc",    {24'd0, instr_pc}, 32'h14);
            check_eq("stall_instr", instr, 32'hC0DE0014);
            check_eq("stall_addr",  {24'd0, rom_addr}, 32'h1C);
            check_eq("stall_count", {16'd0, instr_count}, 32'd5);
        end
        instr_ready = 1'b1;
        expect_stream("release", 8'h14, 5, 30);

        // PC wrap through a redirect to 0xF8
        jump_valid = 1'b1;
        jump_addr  = 8'hF8;
        @(negedge clk);
        jump_valid = 1'b0;
        check_eq("jwrap_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("jwrap_addr",  {24'd0, rom_addr}, 32'hF8);
        expect_stream("wrap", 8'hF8, 4, 20);

        // Fill output and skid, then redirect to 0x40: both are dropped
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("fill_pc",   {24'd0, instr_pc}, 32'h04);
        check_eq("fill_addr", {24'd0, rom_addr}, 32'h0C);
        jump_valid = 1'b1;
        jump_addr  = 8'h40;
        @(negedge clk);
        jump_valid  = 1'b0;
        check_eq("jflush_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("jflush_addr",  {24'd0, rom_addr}, 32'h40);
        instr_ready = 1'b1;
        expect_stream("redirect", 8'h40, 2, 20);
        check_eq("steady_addr", {24'd0, rom_addr}, 32'h4C);

        // Halt: output 0x44 leaves, in-flight 0x48 and the halt-cycle fetch 0x4C drain
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check_eq("halt_flag", {31'd0, halted}, 32'd1);
        expect_stream("halt_drain", 8'h48, 2, 10);
        @(negedge clk);
        check_eq("halt_empty", {31'd0, instr_valid}, 32'd0);
        check_eq("halt_addr",  {24'd0, rom_addr}, 32'h50);
        @(negedge clk);
        check_eq("halt_addr2", {24'd0, rom_addr}, 32'h50);

        // start together with halt: halt wins, stay HALTED
        halt  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        halt  = 1'b0;
        start = 1'b0;
        check_eq("both_halted", {31'd0, halted}, 32'd1);
        @(negedge clk);
        check_eq("both_addr", {24'd0, rom_addr}, 32'h50);

        // Resume from the frozen PC
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("resume_halted", {31'd0, halted}, 32'd0);
        expect_stream("resume", 8'h50, 2, 10);

        // Asynchronous reset mid-stream
        check_eq("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid",  {31'd0, instr_valid}, 32'd0);
        check_eq("arst_instr",  instr, 32'd0);
        check_eq("arst_pc",     {24'd0, instr_pc}, 32'd0);
        check_eq("arst_count",  {16'd0, instr_count}, 32'd0);
        check_eq("arst_halted", {31'd0, halted}, 32'd0);
        check_eq("arst_addr",   {24'd0, rom_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("post_rst_addr",  {24'd0, rom_addr}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_stream("restart", 8'h00, 1, 10);
        @(negedge clk);
        check_eq("restart_count", {16'd0, instr_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
